// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: state encoding reused by the display and LED blocks.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // The second prescaler only advances while a run is counting or holding DONE.
   function automatic logic is_counting(input state_t st);
      return (st == ST_RUN) || (st == ST_DONE);
   endfunction

endpackage

// File: rtl/stopwatch_timer_ctrl_sec_prescaler.sv
// Divides i_clk down to a one-cycle tick every CLK2SEC cycles; holds its count when disabled.
module sec_prescaler #(
   parameter int CLK2SEC = 10
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int CNT_W = (CLK2SEC > 1) ? $clog2(CLK2SEC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK2SEC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             wrap;

   assign wrap   = (cnt_q == CNT_LAST);
   assign o_tick = i_en && wrap;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         cnt_q <= '0;
      end else if (i_clr) begin
         cnt_q <= '0;
      end else if (i_en) begin
         cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/stopwatch_timer_ctrl.sv
// Stopwatch/timer controller: counts seconds up to a latched target with pause, clear and auto-reload.
module stopwatch_timer_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CLK2SEC       = 10,
   parameter int SEC_W         = 6,
   parameter int DONE_HOLD_SEC = 1
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_start,
   input  logic             i_pause,
   input  logic             i_clear,
   input  logic             i_autoreload,
   input  logic [SEC_W-1:0] i_target_sec,
   output logic             o_idle,
   output logic             o_running,
   output logic             o_paused,
   output logic             o_done,
   output logic             o_tick,
   output logic [SEC_W-1:0] o_sec
);

   localparam int HOLD_W = (DONE_HOLD_SEC > 0) ? $clog2(DONE_HOLD_SEC + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_HOLD_SEC - 1);

   state_t              state_q, state_d;
   logic [SEC_W-1:0]    sec_q, sec_d;
   logic [SEC_W-1:0]    target_q, target_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [SEC_W-1:0]    sec_inc;
   logic                presc_en;
   logic                presc_clr;
   logic                tick;

   assign presc_en = is_counting(state_q);
   assign sec_inc  = sec_q + SEC_W'(1);

   sec_prescaler #(
      .CLK2SEC (CLK2SEC)
   ) u_prescaler (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_en   (presc_en),
      .i_clr  (presc_clr),
      .o_tick (tick)
   );

   always_comb begin
      state_d   = state_q;
      sec_d     = sec_q;
      target_d  = target_q;
      hold_d    = hold_q;
      presc_clr = 1'b0;

      if (i_clear) begin
         state_d   = ST_IDLE;
         sec_d     = '0;
         hold_d    = '0;
         presc_clr = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               // A zero target would finish before it starts, so it is not accepted.
               if (i_start && (i_target_sec != '0)) begin
                  state_d   = ST_RUN;
                  target_d  = i_target_sec;
                  sec_d     = '0;
                  hold_d    = '0;
                  presc_clr = 1'b1;
               end
            end
            ST_RUN: begin
               if (tick) begin
                  sec_d = sec_inc;
                  // Reaching the target takes precedence over a coincident pause.
                  if (sec_inc == target_q) begin
                     state_d = ST_DONE;
                     hold_d  = '0;
                  end else if (i_pause) begin
                     state_d = ST_PAUSE;
                  end
               end else if (i_pause) begin
                  state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (i_pause) begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: begin
               if (tick) begin
                  if (hold_q == HOLD_LAST) begin
                     hold_d = '0;
                     if (i_autoreload) begin
                        state_d = ST_RUN;
                        sec_d   = '0;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end else begin
                     hold_d = hold_q + HOLD_W'(1);
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q  <= ST_IDLE;
         sec_q    <= '0;
         target_q <= '0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         sec_q    <= sec_d;
         target_q <= target_d;
         hold_q   <= hold_d;
      end
   end

   assign o_idle    = (state_q == ST_IDLE);
   assign o_running = (state_q == ST_RUN);
   assign o_paused  = (state_q == ST_PAUSE);
   assign o_done    = (state_q == ST_DONE);
   assign o_tick    = tick;
   assign o_sec     = sec_q;

endmodule
